// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR/trap unit.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MIE       = 12'h304;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVAL     = 12'h343;
  localparam logic [11:0] ADR_MIP       = 12'h344;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;

  // Interrupt codes, which double as their mip/mie bit positions
  localparam logic [4:0] IRQ_SW    = 5'd3;
  localparam logic [4:0] IRQ_TIMER = 5'd7;
  localparam logic [4:0] IRQ_EXT   = 5'd11;

  // mstatus bit indices
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;
  // MXL=1 (RV32), extensions I (bit 8) and F (bit 5)
  localparam logic [31:0] MISA_VAL = 32'h4000_0120;

endpackage

// File: rtl/csr_counter.sv
// Performance counter readable/writable as two XLEN halves.
// A write to either half beats the increment for that cycle.
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_lo,
  input  logic            i_wr_hi,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_lo,
  output logic [XLEN-1:0] o_hi
);

  logic [CNT_W-1:0] r_cnt;

  generate
    if (CNT_W > XLEN) begin : g_wide
      // Full-width increment wraps naturally; carry into the high half is same-cycle
      always_ff @(posedge clk) begin
        if (rst)          r_cnt <= '0;
        else if (i_wr_lo) r_cnt[XLEN-1:0] <= i_wdata;
        else if (i_wr_hi) r_cnt[CNT_W-1:XLEN] <= i_wdata[CNT_W-XLEN-1:0];
        else if (i_inc)   r_cnt <= r_cnt + 1'b1;
      end
      assign o_lo = r_cnt[XLEN-1:0];
      assign o_hi = XLEN'(r_cnt[CNT_W-1:XLEN]);
    end else begin : g_narrow
      // Narrow counter: high half does not exist and reads zero
      always_ff @(posedge clk) begin
        if (rst)          r_cnt <= '0;
        else if (i_wr_lo) r_cnt <= i_wdata[CNT_W-1:0];
        else if (i_inc)   r_cnt <= r_cnt + 1'b1;
      end
      assign o_lo = XLEN'(r_cnt);
      assign o_hi = '0;
    end
  endgenerate

endmodule

// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file: registered reads, trap/mret sequencing,
// interrupt arbitration, trap target generation and perf counters.
module csr_mtrap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              CNT_W          = 64,
  parameter int              MTVEC_VECTORED = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET    = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_adr_rd,
  output logic [XLEN-1:0] csr_rddata,
  input  logic [11:0]     csr_adr_wr,
  input  logic [XLEN-1:0] csr_wrdata,
  input  logic            csr_wr_en,
  input  logic            freeze,
  input  logic            trap_en,
  input  logic            trap_is_irq,
  input  logic [4:0]      trap_code,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            instr_retire,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            irq_req,
  output logic [4:0]      irq_code,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] csr_mepc,
  output logic            csr_illegal
);

  logic            r_mst_mie, r_mst_mpie;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_rddata;
  logic [XLEN-1:0] w_mstatus, w_mip, w_pend, w_rd, w_base;
  logic [XLEN-1:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;
  logic            w_ill;

  function automatic logic wr_hit(input logic [11:0] a);
    return csr_wr_en && (csr_adr_wr == a);
  endfunction

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};
  assign w_mip     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign w_pend    = w_mip & r_mie;

  // mstatus: trap stacks MIE, mret unstacks it; both beat a software write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
    end else if (trap_en) begin
      r_mst_mpie <= r_mst_mie;
      r_mst_mie  <= 1'b0;
    end else if (mret) begin
      r_mst_mie  <= r_mst_mpie;
      r_mst_mpie <= 1'b1;
    end else if (wr_hit(ADR_MSTATUS)) begin
      r_mst_mie  <= csr_wrdata[MSTATUS_MIE];
      r_mst_mpie <= csr_wrdata[MSTATUS_MPIE];
    end
  end

  // Trap capture registers; a trap overrides same-cycle software writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (trap_en) begin
      r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
      r_mcause <= {trap_is_irq, {(XLEN-6){1'b0}}, trap_code};
      r_mtval  <= trap_val;
    end else begin
      if (wr_hit(ADR_MEPC))   r_mepc   <= {csr_wrdata[XLEN-1:2], 2'b00};
      if (wr_hit(ADR_MCAUSE)) r_mcause <= csr_wrdata;
      if (wr_hit(ADR_MTVAL))  r_mtval  <= csr_wrdata;
    end
  end

  // Software-only registers; mtvec bit 1 is reserved and stored as 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
    end else begin
      if (wr_hit(ADR_MIE))      r_mie      <= csr_wrdata & MIE_MASK;
      if (wr_hit(ADR_MTVEC))    r_mtvec    <= {csr_wrdata[XLEN-1:2], 1'b0, csr_wrdata[0]};
      if (wr_hit(ADR_MSCRATCH)) r_mscratch <= csr_wrdata;
    end
  end

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_wr_lo (wr_hit(ADR_MCYCLE)),
    .i_wr_hi (wr_hit(ADR_MCYCLEH)),
    .i_wdata (csr_wrdata),
    .i_inc   (1'b1),
    .o_lo    (w_cyc_lo),
    .o_hi    (w_cyc_hi)
  );

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_wr_lo (wr_hit(ADR_MINSTRET)),
    .i_wr_hi (wr_hit(ADR_MINSTRETH)),
    .i_wdata (csr_wrdata),
    .i_inc   (instr_retire),
    .o_lo    (w_ins_lo),
    .o_hi    (w_ins_hi)
  );

  // Read decode; unknown addresses read zero and flag illegal
  always_comb begin
    w_rd  = '0;
    w_ill = 1'b0;
    case (csr_adr_rd)
      ADR_MSTATUS:   w_rd = w_mstatus;
      ADR_MISA:      w_rd = MISA_VAL;
      ADR_MIE:       w_rd = r_mie;
      ADR_MTVEC:     w_rd = r_mtvec;
      ADR_MSCRATCH:  w_rd = r_mscratch;
      ADR_MEPC:      w_rd = r_mepc;
      ADR_MCAUSE:    w_rd = r_mcause;
      ADR_MTVAL:     w_rd = r_mtval;
      ADR_MIP:       w_rd = w_mip;
      ADR_MCYCLE:    w_rd = w_cyc_lo;
      ADR_MINSTRET:  w_rd = w_ins_lo;
      ADR_MCYCLEH:   w_rd = w_cyc_hi;
      ADR_MINSTRETH: w_rd = w_ins_hi;
      ADR_MVENDORID, ADR_MARCHID, ADR_MIMPID, ADR_MHARTID: w_rd = '0;
      default:       w_ill = 1'b1;
    endcase
  end

  // Registered read port, held while frozen
  always_ff @(posedge clk) begin
    if (rst)          r_rddata <= '0;
    else if (!freeze) r_rddata <= w_rd;
  end

  // Interrupt arbitration: ext > sw > timer
  always_comb begin
    irq_code = 5'd0;
    if (w_pend[IRQ_EXT])        irq_code = IRQ_EXT;
    else if (w_pend[IRQ_SW])    irq_code = IRQ_SW;
    else if (w_pend[IRQ_TIMER]) irq_code = IRQ_TIMER;
  end

  assign irq_req = r_mst_mie & (|w_pend);

  assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
  assign trap_target = ((MTVEC_VECTORED != 0) && (r_mtvec[1:0] == 2'b01) && trap_is_irq)
                       ? w_base + {{(XLEN-7){1'b0}}, trap_code, 2'b00}
                       : w_base;

  assign csr_rddata  = r_rddata;
  assign csr_mepc    = r_mepc;
  assign csr_illegal = w_ill;

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Directed bench for csr_mtrap_unit with a cycle-level reference model.
module tb_csr_mtrap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_adr_rd = '0, csr_adr_wr = '0;
  logic [31:0] csr_rddata, csr_wrdata = '0;
  logic        csr_wr_en = 0, freeze = 0, trap_en = 0, trap_is_irq = 0, mret = 0;
  logic [4:0]  trap_code = '0;
  logic [31:0] trap_pc = '0, trap_val = '0;
  logic        instr_retire = 0, irq_sw = 0, irq_timer = 0, irq_ext = 0;
  logic        irq_req, csr_illegal;
  logic [4:0]  irq_code;
  logic [31:0] trap_target, csr_mepc;

  int n_chk = 0, n_fail = 0;

  csr_mtrap_unit dut (
    .clk(clk), .rst(rst), .csr_adr_rd(csr_adr_rd), .csr_rddata(csr_rddata),
    .csr_adr_wr(csr_adr_wr), .csr_wrdata(csr_wrdata), .csr_wr_en(csr_wr_en),
    .freeze(freeze), .trap_en(trap_en), .trap_is_irq(trap_is_irq),
    .trap_code(trap_code), .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret),
    .instr_retire(instr_retire), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .irq_ext(irq_ext), .irq_req(irq_req), .irq_code(irq_code),
    .trap_target(trap_target), .csr_mepc(csr_mepc), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 0;
  bit          m_MIE, m_MPIE;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_rd;
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit ill);
    ill = 0;
    case (a)
      12'h300: return 32'h1800 | (32'(m_MPIE) << 7) | (32'(m_MIE) << 3);
      12'h301: return 32'h4000_0120;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 32'h0;
      default: begin ill = 1; return 32'h0; end
    endcase
  endfunction

  // Compare mid-cycle, then advance the model to the state after the next edge
  always @(negedge clk) begin
    bit          ill;
    logic [31:0] rd_now, nrd, base, pend, tgt;
    logic [4:0]  code;
    if (m_ok) begin
      rd_now = m_read(csr_adr_rd, ill);
      pend = m_mie & ((32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3));
      code = pend[11] ? 5'd11 : pend[3] ? 5'd3 : pend[7] ? 5'd7 : 5'd0;
      base = m_mtvec & ~32'h3;
      tgt  = (m_mtvec[1:0] == 2'b01 && trap_is_irq) ? base + 32'(trap_code) * 4 : base;
      chk("m_rddata", csr_rddata, m_rd);
      chk("m_illegal", 32'(csr_illegal), 32'(ill));
      chk("m_irq_req", 32'(irq_req), 32'(m_MIE && pend != 0));
      chk("m_irq_code", 32'(irq_code), 32'(code));
      chk("m_trap_target", trap_target, tgt);
      chk("m_mepc", csr_mepc, m_mepc);
    end
    if (rst) begin
      m_MIE = 0; m_MPIE = 0; m_mie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
      m_mtval = 0; m_mscratch = 0; m_cyc = 0; m_ins = 0; m_rd = 0; m_ok = 1;
    end else if (m_ok) begin
      nrd = freeze ? m_rd : m_read(csr_adr_rd, ill);
      if (csr_wr_en) case (csr_adr_wr)
        12'h304: m_mie      = csr_wrdata & 32'h888;
        12'h305: m_mtvec    = csr_wrdata & ~32'h2;
        12'h340: m_mscratch = csr_wrdata;
        default: ;
      endcase
      if (csr_wr_en && csr_adr_wr == 12'hB00)      m_cyc[31:0]  = csr_wrdata;
      else if (csr_wr_en && csr_adr_wr == 12'hB80) m_cyc[63:32] = csr_wrdata;
      else                                         m_cyc        = m_cyc + 1;
      if (csr_wr_en && csr_adr_wr == 12'hB02)      m_ins[31:0]  = csr_wrdata;
      else if (csr_wr_en && csr_adr_wr == 12'hB82) m_ins[63:32] = csr_wrdata;
      else if (instr_retire)                       m_ins        = m_ins + 1;
      if (trap_en) begin
        m_mepc = trap_pc & ~32'h3;
        m_mcause = (32'(trap_is_irq) << 31) | 32'(trap_code);
        m_mtval = trap_val;
        m_MPIE = m_MIE; m_MIE = 0;
      end else begin
        if (mret) begin m_MIE = m_MPIE; m_MPIE = 1; end
        else if (csr_wr_en && csr_adr_wr == 12'h300) begin
          m_MIE = csr_wrdata[3]; m_MPIE = csr_wrdata[7];
        end
        if (csr_wr_en && csr_adr_wr == 12'h341) m_mepc   = csr_wrdata & ~32'h3;
        if (csr_wr_en && csr_adr_wr == 12'h342) m_mcause = csr_wrdata;
        if (csr_wr_en && csr_adr_wr == 12'h343) m_mtval  = csr_wrdata;
      end
      m_rd = nrd;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_adr_wr = a; csr_wrdata = d; csr_wr_en = 1; step(); csr_wr_en = 0;
  endtask

  initial begin
    step(); step(); rst = 0;
    // Reset values and first read
    csr_adr_rd = 12'h305; #1;
    chk("rst_irq_req", 32'(irq_req), 0);
    chk("rst_trap_target", trap_target, 32'h100);
    step();
    chk("rd_mtvec_rst", csr_rddata, 32'h100);
    csr_adr_rd = 12'h7C0; #1;
    chk("illegal_7c0", 32'(csr_illegal), 1);
    step();
    chk("rd_7c0", csr_rddata, 0);

    // Enable timer interrupt, trap on it, then return
    wr(12'h300, 32'h8); wr(12'h304, 32'h80);
    irq_timer = 1; #1;
    chk("irq_req_timer", 32'(irq_req), 1);
    chk("irq_code_timer", 32'(irq_code), 7);
    trap_en = 1; trap_is_irq = 1; trap_code = 5'd7; trap_pc = 32'h2000; trap_val = 0;
    step(); trap_en = 0; #1;
    chk("mepc_trap", csr_mepc, 32'h2000);
    chk("irq_req_after_trap", 32'(irq_req), 0);
    csr_adr_rd = 12'h342; step();
    chk("mcause_trap", csr_rddata, 32'h8000_0007);
    csr_adr_rd = 12'h300; step();
    chk("mstatus_trap", csr_rddata, 32'h1880);
    mret = 1; step(); mret = 0; step();
    chk("mstatus_mret", csr_rddata, 32'h1888);
    irq_ext = 1; irq_sw = 1; #1;
    chk("irq_code_prio_masked", 32'(irq_code), 7);
    irq_ext = 0; irq_sw = 0; irq_timer = 0;

    // Vectored / direct targets; mtvec bit 1 drops
    wr(12'h305, 32'h403);
    trap_is_irq = 1; trap_code = 5'd11; #1;
    chk("target_vec_irq11", trap_target, 32'h42C);
    trap_is_irq = 0; trap_code = 5'd2; #1;
    chk("target_exc2", trap_target, 32'h400);
    csr_adr_rd = 12'h305; step();
    chk("mtvec_bit1", csr_rddata, 32'h401);

    // Counter carry into the high half
    wr(12'hB00, 32'hFFFF_FFFF); wr(12'hB80, 32'h5);
    csr_adr_rd = 12'hB80; step();
    chk("mcycleh_written", csr_rddata, 32'h5);
    step();
    chk("mcycleh_carry", csr_rddata, 32'h6);
    csr_adr_rd = 12'hB00; step();
    chk("mcycle_wrapped", csr_rddata, 32'h1);
    instr_retire = 1; step(); step(); step(); instr_retire = 0;
    csr_adr_rd = 12'hB02; step();
    chk("minstret_3", csr_rddata, 32'h3);

    // Trap beats mepc write; trap beats mret
    csr_adr_wr = 12'h341; csr_wrdata = 32'h80; csr_wr_en = 1;
    trap_en = 1; trap_is_irq = 0; trap_code = 5'd2; trap_pc = 32'h40; trap_val = 32'h55;
    step(); csr_wr_en = 0; trap_en = 0; #1;
    chk("trap_beats_wr", csr_mepc, 32'h40);
    trap_en = 1; mret = 1; step(); trap_en = 0; mret = 0;
    csr_adr_rd = 12'h300; step();
    chk("trap_beats_mret", csr_rddata, 32'h1800);

    // Freeze holds read data
    csr_adr_rd = 12'h341; step();
    freeze = 1; csr_adr_rd = 12'h300; step(); csr_adr_rd = 12'h342; step();
    chk("freeze_hold", csr_rddata, 32'h40);
    freeze = 0;

    // Read-only drop, scratch, reset during write
    wr(12'h301, 32'h0); csr_adr_rd = 12'h301; step();
    chk("misa_ro", csr_rddata, 32'h4000_0120);
    wr(12'h340, 32'hDEAD_BEEF); csr_adr_rd = 12'h340; step();
    chk("mscratch", csr_rddata, 32'hDEAD_BEEF);
    rst = 1; wr(12'h340, 32'h1234); rst = 0;
    step();
    chk("rst_mid_write", csr_rddata, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_mtrap_unit.md
# csr_mtrap_unit

Parametrised machine-mode CSR file with full trap/return sequencing, interrupt arbitration and 64-bit performance counters. It sits beside the ID/EX stage. It provides:
- registered CSR reads;
- write-port updates from the CSR instruction path;
- hardware-owned MIE/MPIE stacking on trap and `mret`;
- mcause/mepc/mtval capture;
- a direct or vectored trap target;
- mcycle/minstret counting.

## Interface
Parameters:
- XLEN, 32 — data width of every CSR.
- CNT_W, 64 — counter width; legal values are 32 or 64. When CNT_W is 32, the `h` halves read 0.
- MTVEC_VECTORED, 1 — 1 enables vectored mode when mtvec[1:0]=01; 0 forces direct mode.
- MTVEC_RESET, 32'h0000_0100 — reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_adr_rd  in  12  read address
- csr_rddata  out  XLEN  registered read data
- csr_adr_wr  in  12  write address
- csr_wrdata  in  XLEN  write data
- csr_wr_en  in  1  write strobe
- freeze  in  1  holds csr_rddata
- trap_en  in  1  take trap this cycle
- trap_is_irq  in  1  trap is an interrupt
- trap_code  in  5  exception/interrupt code
- trap_pc  in  XLEN  pc of the trapping instruction
- trap_val  in  XLEN  faulting addr/instr, written to mtval
- mret  in  1  return from trap
- instr_retire  in  1  one instruction retired
- irq_sw, irq_timer, irq_ext  in  1 each  level interrupt lines
- irq_req  out  1  an enabled interrupt is pending and mstatus.MIE=1
- irq_code  out  5  code of the winning interrupt
- trap_target  out  XLEN  combinational handler address
- csr_mepc  out  XLEN  current mepc
- csr_illegal  out  1  csr_adr_rd is unimplemented, combinational

## Operation
- Implemented addresses:
  - mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP[12:11] read 11; all other bits read 0)
  - misa 0x301 (read-only)
  - mie 0x304 (bits 3/7/11 writable)
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341 (bits [1:0] forced 0)
  - mcause 0x342
  - mtval 0x343
  - mip 0x344 (read-only, {irq_ext,irq_timer,irq_sw} at bits 11/7/3)
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82
  - mvendorid/marchid/mimpid/mhartid read 0
- Any other read address returns 0 and raises csr_illegal. Writes to read-only or unimplemented addresses are dropped.
- Trap: mepc←trap_pc; mcause←{trap_is_irq,26'b0,trap_code}; mtval←trap_val; MPIE←MIE; MIE←0.
- `mret`: MIE←MPIE; MPIE←1.
- Interrupt priority: ext(11) > sw(3) > timer(7). irq_code takes the highest-priority value among mip&mie. irq_req = MIE & |(mip&mie).
- trap_target:
  - vectored (MTVEC_VECTORED=1 and mtvec[1:0]=01) and trap_is_irq: {mtvec[31:2],2'b00}+4·trap_code.
  - otherwise: {mtvec[31:2],2'b00}.
  - mtvec[1] is written as 0.
- Counters:
  - mcycle increments every cycle that is not in reset.
  - minstret increments when instr_retire=1.
  - Both wrap from all-ones to 0. The carry from the low word into the high word happens in the same cycle.
- Conflict rules:
  - trap_en beats a same-cycle csr_wr_en to mstatus/mepc/mcause/mtval; writes to other addresses still land.
  - trap_en beats mret; mret is ignored.
  - A CSR write to a counter half beats that cycle's increment: the written half takes csr_wrdata, and the other half is unchanged (no carry).
- Reset values: mstatus MIE=0, MPIE=0; mie 0; mtvec MTVEC_RESET; mepc, mcause, mtval, mscratch 0; counters 0; csr_rddata 0.
  - Combinational outputs after reset: irq_req 0, irq_code 0, trap_target=MTVEC_RESET.

## Timing
- Read latency is 1: csr_rddata at edge N+1 reflects state before edge N+1, sampling csr_adr_rd from cycle N. There is no write→read bypass, so a same-cycle write returns the old value.
- freeze=1: csr_rddata holds. State updates and counters continue.
- Writes, trap and mret take effect at the next edge. irq_req reflects the updated MIE one cycle after a trap.
- rst asserted mid-trap or mid-write: reset wins and all state returns to reset values at that edge.

## Structure
- Package `csr_pkg` holds:
  - CSR address localparams
  - interrupt codes (3/7/11) and mstatus bit indices
  - mie mask 32'h0000_0888
  - misa constant (RV32I+F)
- Sub-module `csr_counter` (CNT_W, lo/hi write enables, inc, wrap) is instantiated twice, for mcycle and minstret.

## Test plan
- Reset, then read 0x305 → 0x100 one cycle later. Read 0x7C0 → 0 with csr_illegal=1.
- Write mstatus=0x8, mie=0x80, raise irq_timer → irq_req=1, irq_code=7. Then assert trap_en (irq, code 7, pc 0x2000) → mepc=0x2000, mcause=0x8000_0007, MIE=0, MPIE=1, irq_req=0. Then mret → MIE=1.
- mtvec=0x401, MTVEC_VECTORED=1, trap irq code 11 → trap_target=0x42C. Exception code 2 → trap_target=0x400.
- Write mcycle=0xFFFF_FFFF, mcycleh=5 → two cycles later mcycleh=6 and mcycle low word wrapped through 0.
- Same-cycle trap_en (pc 0x40) and csr write mepc=0x80 → mepc=0x40. Same-cycle trap_en and mret → mret ignored.
- Hold freeze=1 while changing csr_adr_rd → csr_rddata is unchanged.
